dice_roll_ctrl: RTL and testbench
=================================

# dice_roll_ctrl

Roll controller for the dice-roller design. It sits between the seven raw die-select buttons and the two-digit 7-segment display driver. It debounces and normalises button polarity, and arbitrates simultaneous presses to a single owner. It runs a BCD roll counter while the owning button is held and presents a spinning, then latched, two-digit BCD result for the display multiplexer.

## Interface
Parameters:
- `DEB_CYCLES`, default 50000: clock cycles between debounce sample ticks.
- `SPIN_CYCLES`, default 400000: clock cycles between display snapshots while rolling.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous reset, active-high. The top level drives it from `~rst_n`.
- `btn_raw`  in  7  raw buttons. Bit 0..6 = d4, d6, d8, d10, d12, d20, d100.
- `btn_pol`  in  1  button polarity. 1 = pressed reads 1; 0 = pressed reads 0.
- `tens`  out  4  BCD tens digit to display.
- `ones`  out  4  BCD ones digit to display.
- `tens_blank`  out  1  display driver blanks the tens digit.
- `rolling`  out  1  a roll is in progress; display shows the spin snapshot.
- `valid`  out  1  `tens`/`ones` hold a final result.
- `sel_die`  out  3  index (0..6) of the die currently owning or last rolled.

## Operation
- **Normalise:** `p = btn_pol ? btn_raw : ~btn_raw`.
- **Debounce:**
  - A shared tick fires every `DEB_CYCLES` cycles.
  - `deb[i]` takes the value of `p[i]` only when the last two tick samples agree.
  - `deb` resets to 0.
- **Edges:** `press[i] = deb[i] & ~deb_q[i]` and `rel[i] = ~deb[i] & deb_q[i]`, with `deb_q` registered each cycle.
- **FSM states:** IDLE, ROLL, SHOW.
  - IDLE/SHOW → ROLL on any `press`. If several presses occur in the same cycle, the lowest index wins. `sel_die` takes the owner's index and the counter loads BCD 01.
  - ROLL: presses and releases of non-owner buttons are ignored.
  - ROLL → SHOW on `rel[sel_die]`. The final value is the counter value in that cycle.
  - SHOW: a new press starts a new roll. Buttons still held from earlier never restart a roll without a fresh debounced press.
- **Roll counter:**
  - 8-bit packed BCD, advancing every cycle in ROLL and cycling 1..N.
  - N = 4, 6, 8, 10, 12, 20, 100.
  - Wrap is N → 01. For d100, value 100 is encoded "00".
- **Spin display:** in ROLL, `tens`/`ones` copy the counter on ROLL entry and then every `SPIN_CYCLES` cycles.
- **Blanking:** `tens_blank = (tens==0) && (sel_die != d100)`. d100 always shows two digits, "00" = 100. Blanking applies in both ROLL and SHOW; in IDLE it is 1.
- **Polarity change:** a change of `btn_pol` is treated as ordinary input. It passes through the debounce, and any resulting edges are processed normally.

## Timing
- **Reset values:**
  - State IDLE.
  - `tens` = `ones` = 0, `tens_blank` = 1.
  - `rolling` = 0, `valid` = 0, `sel_die` = 0.
  - `deb`, `deb_q`, counter and tick counters = 0.
- **Press latency:** `deb` rises on the second agreeing tick. `rolling` = 1, `valid` = 0 and `sel_die` update on the next clock edge.
- **Release latency:** `rel` seen in cycle c. At edge c+1, `rolling` = 0, `valid` = 1 and `tens`/`ones` = the counter value of cycle c.
- **Counter sequence:** cycle k of ROLL (k = 1 on entry) holds value ((k−1) mod N) + 1.
- **Simultaneous events:**
  - Owner release and a non-owner press in the same cycle: go to SHOW, and the press is discarded.
  - Owner press and release cannot coincide, because of the debounce.
- **Reset mid-ROLL:** immediate return to IDLE with reset values. The pending roll is discarded.

## Structure
- Package `dice_pkg`:
  - die index constants `DIE_D4` .. `DIE_D100`;
  - BCD maximum table `DIE_MAX_BCD` (04, 06, 08, 10, 12, 20, 00);
  - FSM state enum `roll_state_t`.
- One sub-module, `btn_debounce`: 7-bit vector, shared tick, `DEB_CYCLES` parameter, synchronous active-high reset, outputs `deb`.
- FSM, BCD counter, spin snapshot and blanking stay in `dice_roll_ctrl`.

## Test plan
Bench parameters: `DEB_CYCLES` = 4, `SPIN_CYCLES` = 8.

1. Assert `rst` for 3 cycles → `tens`=0, `ones`=0, `tens_blank`=1, `rolling`=0, `valid`=0, `sel_die`=0.
2. `btn_pol`=1, hold d6 so ROLL lasts 13 cycles → `valid`=1, `ones`=1, `tens_blank`=1, `sel_die`=1. Repeat with d20 and ROLL of 25 cycles → `ones`=5.
3. d100 with ROLL of 100 cycles → `tens`=0, `ones`=0, `tens_blank`=0. With ROLL of 42 cycles → `tens`=4, `ones`=2.
4. d8 and d20 pressed in the same tick → `sel_die`=2. Releasing d20 first leaves `rolling`=1; releasing d8 ends the roll. Holding d20 afterwards starts no roll.
5. `btn_pol`=0: a d4 line held low for 3 ticks → roll starts. A glitch lasting less than 2 ticks → no state change.
6. `rst` pulsed mid-ROLL of d12 → next cycle IDLE, `rolling`=0, `valid`=0, `tens_blank`=1.

Source files
------------

// File: rtl/dice_pkg.sv
// Shared definitions for the dice-roller roll controller: die indices,
// per-die BCD maxima, FSM state type and small BCD/arbitration helpers.
package dice_pkg;

  localparam int unsigned NUM_DICE = 7;

  localparam logic [2:0] DIE_D4   = 3'd0;
  localparam logic [2:0] DIE_D6   = 3'd1;
  localparam logic [2:0] DIE_D8   = 3'd2;
  localparam logic [2:0] DIE_D10  = 3'd3;
  localparam logic [2:0] DIE_D12  = 3'd4;
  localparam logic [2:0] DIE_D20  = 3'd5;
  localparam logic [2:0] DIE_D100 = 3'd6;

  // Packed BCD maximum per die, element 0 = d4. The d100 maximum of 100
  // is encoded as "00" so it fits the two-digit counter.
  localparam logic [6:0][7:0] DIE_MAX_BCD = {
    8'h00, 8'h20, 8'h12, 8'h10, 8'h08, 8'h06, 8'h04
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROLL = 2'd1,
    ST_SHOW = 2'd2
  } roll_state_t;

  // Two-digit packed BCD increment, 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] t;
    logic [3:0] o;
    t = v[7:4];
    o = v[3:0];
    if (o >= 4'd9) begin
      o = 4'd0;
      if (t >= 4'd9) begin
        t = 4'd0;
      end else begin
        t = t + 4'd1;
      end
    end else begin
      o = o + 4'd1;
    end
    return {t, o};
  endfunction

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [2:0] lowest_index(input logic [6:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (v[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Vector debouncer: one shared sample tick; each bit follows its input
// only when two consecutive tick samples agree.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 50000,
  parameter int unsigned WIDTH      = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] deb
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [CW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [WIDTH-1:0] smp_q, smp_d;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] agree_s;
  logic             tick_s;

  assign tick_s  = (tick_cnt_q == CW'(DEB_CYCLES - 1));
  assign agree_s = ~(din ^ smp_q);
  assign deb     = deb_q;

  // Tick divider and per-bit agreement filter.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    smp_d      = smp_q;
    deb_d      = deb_q;
    if (tick_s) begin
      tick_cnt_d = '0;
      smp_d      = din;
      deb_d      = (agree_s & din) | (~agree_s & deb_q);
    end else begin
      tick_cnt_d = tick_cnt_q + CW'(1);
    end
  end

  // Debounce state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
      smp_q      <= '0;
      deb_q      <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      smp_q      <= smp_d;
      deb_q      <= deb_d;
    end
  end

endmodule

// File: rtl/dice_roll_ctrl.sv
// Roll controller: normalises and debounces the die buttons, arbitrates a
// single owner, runs the BCD roll counter and drives the two-digit display.
module dice_roll_ctrl
  import dice_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 50000,
  parameter int unsigned SPIN_CYCLES = 400000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] btn_raw,
  input  logic       btn_pol,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       tens_blank,
  output logic       rolling,
  output logic       valid,
  output logic [2:0] sel_die
);

  localparam int unsigned SW = (SPIN_CYCLES > 1) ? $clog2(SPIN_CYCLES) : 1;

  roll_state_t state_q, state_d;
  logic [6:0]  p_s, deb_s, deb_q, press_s, rel_s;
  logic [2:0]  sel_q, sel_d;
  logic [7:0]  cnt_q, cnt_d, cnt_max_s;
  logic [SW-1:0] spin_q, spin_d;
  logic [3:0]  tens_q, tens_d, ones_q, ones_d;
  logic        blank_q, blank_d;
  logic        rolling_q, rolling_d;
  logic        valid_q, valid_d;

  assign p_s       = btn_pol ? btn_raw : ~btn_raw;
  assign press_s   = deb_s & ~deb_q;
  assign rel_s     = ~deb_s & deb_q;
  assign cnt_max_s = DIE_MAX_BCD[sel_q];

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .WIDTH      (NUM_DICE)
  ) u_debounce (
    .clk (clk),
    .rst (rst),
    .din (p_s),
    .deb (deb_s)
  );

  // Next-state, counter, spin snapshot and display logic.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    spin_d    = spin_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    rolling_d = rolling_q;
    valid_d   = valid_q;
    case (state_q)
      ST_IDLE, ST_SHOW: begin
        if (|press_s) begin
          state_d   = ST_ROLL;
          sel_d     = lowest_index(press_s);
          cnt_d     = 8'h01;
          spin_d    = '0;
          tens_d    = 4'd0;
          ones_d    = 4'd1;
          rolling_d = 1'b1;
          valid_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_ROLL: begin
        if (rel_s[sel_q]) begin
          // Latch the value the counter holds in the release cycle.
          state_d   = ST_SHOW;
          tens_d    = cnt_q[7:4];
          ones_d    = cnt_q[3:0];
          rolling_d = 1'b0;
          valid_d   = 1'b1;
        end else begin
          if (cnt_q == cnt_max_s) begin
            cnt_d = 8'h01;
          end else begin
            cnt_d = bcd_inc(cnt_q);
          end
          if (spin_q == SW'(SPIN_CYCLES - 1)) begin
            spin_d = '0;
            tens_d = cnt_q[7:4];
            ones_d = cnt_q[3:0];
          end else begin
            spin_d = spin_q + SW'(1);
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        sel_d     = 3'd0;
        cnt_d     = 8'h00;
        spin_d    = '0;
        tens_d    = 4'd0;
        ones_d    = 4'd0;
        rolling_d = 1'b0;
        valid_d   = 1'b0;
      end
    endcase
    // d100 always shows both digits ("00" means 100).
    if (state_d == ST_IDLE) begin
      blank_d = 1'b1;
    end else begin
      blank_d = (tens_d == 4'd0) && (sel_d != DIE_D100);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      deb_q     <= 7'd0;
      sel_q     <= 3'd0;
      cnt_q     <= 8'h00;
      spin_q    <= '0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      blank_q   <= 1'b1;
      rolling_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_q     <= deb_s;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      spin_q    <= spin_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      blank_q   <= blank_d;
      rolling_q <= rolling_d;
      valid_q   <= valid_d;
    end
  end

  assign tens       = tens_q;
  assign ones       = ones_q;
  assign tens_blank = blank_q;
  assign rolling    = rolling_q;
  assign valid      = valid_q;
  assign sel_die    = sel_q;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Directed bench for dice_roll_ctrl with DEB_CYCLES=4, SPIN_CYCLES=8.
// A button held for 4*M clock cycles is seen by exactly M debounce ticks,
// so the roll lasts L = 4*M cycles and the result is ((L-1) mod N) + 1.
module tb_dice_roll_ctrl;

  logic       clk;
  logic       rst;
  logic [6:0] btn_raw;
  logic       btn_pol;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       tens_blank;
  logic       rolling;
  logic       valid;
  logic [2:0] sel_die;

  int n_checks;
  int n_fail;

  dice_roll_ctrl #(
    .DEB_CYCLES  (4),
    .SPIN_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_pol    (btn_pol),
    .tens       (tens),
    .ones       (ones),
    .tens_blank (tens_blank),
    .rolling    (rolling),
    .valid      (valid),
    .sel_die    (sel_die)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold one die for 4*m cycles (m >= 3) with btn_pol=1, then release and
  // check the latched result.
  task automatic roll(input string tag, input int die, input int m,
                      input logic [3:0] exp_t, input logic [3:0] exp_o,
                      input logic exp_blank);
    btn_raw[die] = 1'b1;
    step(12);
    check_val({tag, "_rolling"}, rolling, 1'b1);
    check_val({tag, "_valid_mid"}, valid, 1'b0);
    check_val({tag, "_sel_mid"}, sel_die, die);
    step(4 * m - 12);
    btn_raw[die] = 1'b0;
    step(12);
    check_val({tag, "_valid"}, valid, 1'b1);
    check_val({tag, "_rolling_end"}, rolling, 1'b0);
    check_val({tag, "_tens"}, tens, exp_t);
    check_val({tag, "_ones"}, ones, exp_o);
    check_val({tag, "_blank"}, tens_blank, exp_blank);
    check_val({tag, "_sel"}, sel_die, die);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    btn_raw  = 7'h00;
    btn_pol  = 1'b1;

    // Reset state.
    step(3);
    check_val("rst_tens", tens, 4'd0);
    check_val("rst_ones", ones, 4'd0);
    check_val("rst_blank", tens_blank, 1'b1);
    check_val("rst_rolling", rolling, 1'b0);
    check_val("rst_valid", valid, 1'b0);
    check_val("rst_sel", sel_die, 3'd0);
    rst = 1'b0;
    step(4);
    check_val("idle_rolling", rolling, 1'b0);

    // Single-die rolls: L=12 on d6 -> 6; L=16 on d6 -> 4;
    // L=20 on d20 -> 20 (wrap boundary); L=24 on d20 -> 4.
    roll("d6_l12", 1, 3, 4'd0, 4'd6, 1'b1);
    roll("d6_l16", 1, 4, 4'd0, 4'd4, 1'b1);
    roll("d20_l20", 5, 5, 4'd2, 4'd0, 1'b0);
    roll("d20_l24", 5, 6, 4'd0, 4'd4, 1'b1);
    // d100: L=100 -> "00" shown unblanked; L=44 -> 44.
    roll("d100_l100", 6, 25, 4'd0, 4'd0, 1'b0);
    roll("d100_l44", 6, 11, 4'd4, 4'd4, 1'b0);

    // d8 and d20 pressed together: lowest index (d8) owns the roll.
    btn_raw[2] = 1'b1;
    btn_raw[5] = 1'b1;
    step(12);
    check_val("arb_sel", sel_die, 3'd2);
    btn_raw[5] = 1'b0;
    step(12);
    check_val("arb_nonowner_rel", rolling, 1'b1);
    check_val("arb_sel_hold", sel_die, 3'd2);
    btn_raw[5] = 1'b1;
    step(12);
    check_val("arb_nonowner_press", rolling, 1'b1);
    // d8 held 36 cycles -> L=36 -> ((35 mod 8) + 1) = 4.
    btn_raw[2] = 1'b0;
    step(12);
    check_val("arb_valid", valid, 1'b1);
    check_val("arb_rolling_end", rolling, 1'b0);
    check_val("arb_ones", ones, 4'd4);
    step(40);
    check_val("arb_held_no_roll", rolling, 1'b0);
    check_val("arb_held_valid", valid, 1'b1);
    btn_raw[5] = 1'b0;
    step(12);

    // Active-low buttons: switch polarity with all lines idle-high.
    btn_raw = 7'h7F;
    btn_pol = 1'b0;
    step(12);
    check_val("pol_switch_quiet", rolling, 1'b0);
    btn_raw[0] = 1'b0;
    step(12);
    check_val("pol0_rolling", rolling, 1'b1);
    check_val("pol0_sel", sel_die, 3'd0);
    btn_raw[0] = 1'b1;
    step(12);
    // d4 held 12 cycles -> L=12 -> ((11 mod 4) + 1) = 4.
    check_val("pol0_valid", valid, 1'b1);
    check_val("pol0_ones", ones, 4'd4);
    // One-tick glitch must not start a roll.
    btn_raw[0] = 1'b0;
    step(4);
    btn_raw[0] = 1'b1;
    step(16);
    check_val("glitch_rolling", rolling, 1'b0);
    check_val("glitch_valid", valid, 1'b1);
    check_val("glitch_ones", ones, 4'd4);
    btn_pol = 1'b1;
    btn_raw = 7'h00;
    step(12);

    // Reset in the middle of a d12 roll.
    btn_raw[4] = 1'b1;
    step(16);
    check_val("d12_rolling", rolling, 1'b1);
    check_val("d12_sel", sel_die, 3'd4);
    rst        = 1'b1;
    btn_raw[4] = 1'b0;
    step(1);
    check_val("midrst_rolling", rolling, 1'b0);
    check_val("midrst_valid", valid, 1'b0);
    check_val("midrst_blank", tens_blank, 1'b1);
    check_val("midrst_tens", tens, 4'd0);
    check_val("midrst_ones", ones, 4'd0);
    check_val("midrst_sel", sel_die, 3'd0);
    rst = 1'b0;
    step(20);
    check_val("postrst_rolling", rolling, 1'b0);
    check_val("postrst_valid", valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
